// File: rtl/blkop_sequencer_if.sv
// Shared data-memory port used by the block-operation sequencer.
// Handshake: an access is transferred on every rising edge where mem_req && mem_gnt;
// mem_we/mem_addr/mem_wdata are held while mem_req is high and mem_gnt is low,
// and read data arrives on mem_rdata the cycle after a granted read.
interface blkop_sequencer_if #(
   parameter int ADDR_W = 19,
   parameter int DATA_W = 19
) ();
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_gnt;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_gnt, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_gnt, mem_rdata
   );
endinterface

// File: rtl/blkop_sequencer.sv
// Multi-cycle read-transform-write sequencer for the CPU's block operations
// (FFT increment, ENC, DEC) over a single request/grant memory port.
module blkop_sequencer #(
   parameter int              DATA_W  = 19,
   parameter int              ADDR_W  = 19,
   parameter int              BLK_LEN = 8,
   parameter logic [DATA_W-1:0] KEY   = 19'h55555
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_i,
   input  logic [1:0]        op_i,
   input  logic [ADDR_W-1:0] dst_base_i,
   input  logic [ADDR_W-1:0] src_base_i,
   input  logic              abort_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o,
   output logic [2:0]        state_dbg_o,
   blkop_sequencer_if.master mem
);

   localparam int IDX_W = (BLK_LEN > 1) ? $clog2(BLK_LEN) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BLK_LEN - 1);
   localparam logic [1:0] OP_FFT = 2'b00;
   localparam logic [1:0] OP_RSV = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RD_REQ  = 3'd1,
      S_RD_WAIT = 3'd2,
      S_WR_REQ  = 3'd3,
      S_FIN     = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [1:0]        op_q, op_d;
   logic [ADDR_W-1:0] src_q, src_d;
   logic [ADDR_W-1:0] dst_q, dst_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              req_q, req_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      op_d    = op_q;
      src_d   = src_q;
      dst_d   = dst_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               if (op_i == OP_RSV) begin
                  err_d = 1'b1;
               end else begin
                  op_d    = op_i;
                  src_d   = src_base_i;
                  dst_d   = dst_base_i;
                  idx_d   = '0;
                  state_d = S_RD_REQ;
               end
            end
         end
         S_RD_REQ: begin
            if (mem.mem_gnt) state_d = S_RD_WAIT;
         end
         S_RD_WAIT: begin
            // Transformed word goes straight into the write-data register.
            wdata_d = (op_q == OP_FFT) ? (mem.mem_rdata + DATA_W'(1))
                                       : (mem.mem_rdata ^ KEY);
            state_d = S_WR_REQ;
         end
         S_WR_REQ: begin
            if (mem.mem_gnt) begin
               if (idx_q == IDX_LAST) begin
                  state_d = S_FIN;
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  state_d = S_RD_REQ;
               end
            end
         end
         S_FIN: begin
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (abort_i && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
         err_d   = 1'b1;
         done_d  = 1'b0;
      end

      // Registered outputs are derived from the state being entered.
      busy_d = (state_d != S_IDLE);
      req_d  = (state_d == S_RD_REQ) || (state_d == S_WR_REQ);
      we_d   = (state_d == S_WR_REQ);
      if (state_d == S_RD_REQ) addr_d = src_d + ADDR_W'(idx_d);
      if (state_d == S_WR_REQ) addr_d = dst_d + ADDR_W'(idx_d);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         op_q    <= '0;
         src_q   <= '0;
         dst_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         op_q    <= op_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign err_o         = err_q;
   assign state_dbg_o   = state_q;
   assign mem.mem_req   = req_q;
   assign mem.mem_we    = we_q;
   assign mem.mem_addr  = addr_q;
   assign mem.mem_wdata = wdata_q;

endmodule
